// File: rtl/cc_hit_miss_dispatch.sv
// Hit/miss dispatch: feeds the read-data reorder FIFOs with the ordered
// hit/miss flag and hit data, and issues a wrap AR burst for each miss.
module cc_hit_miss_dispatch #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 512,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tc_valid_i,
    output logic                    tc_ready_o,
    input  logic                    tc_hit_i,
    input  logic [ADDR_WIDTH-1:0]   tc_addr_i,
    input  logic [LINE_WIDTH-1:0]   tc_line_i,
    input  logic                    hit_flag_fifo_afull_i,
    output logic                    hit_flag_fifo_wren_o,
    output logic                    hit_flag_fifo_wdata_o,
    input  logic                    hit_data_fifo_afull_i,
    output logic                    hit_data_fifo_wren_o,
    output logic [LINE_WIDTH+5:0]   hit_data_fifo_wdata_o,
    output logic [ADDR_WIDTH-1:0]   mem_araddr_o,
    output logic [3:0]              mem_arlen_o,
    output logic [2:0]              mem_arsize_o,
    output logic [1:0]              mem_arburst_o,
    output logic                    mem_arvalid_o,
    input  logic                    mem_arready_i,
    output logic [CNT_WIDTH-1:0]    hit_cnt_o,
    output logic [CNT_WIDTH-1:0]    miss_cnt_o
);

    localparam int DATA_W = LINE_WIDTH + 6;

    typedef enum logic [0:0] {
        IDLE,
        AR_WAIT
    } state_e;

    state_e                  state_q, state_d;
    logic                    flag_wren_q, flag_wren_d;
    logic                    flag_wdata_q, flag_wdata_d;
    logic                    data_wren_q, data_wren_d;
    logic [DATA_W-1:0]       data_wdata_q, data_wdata_d;
    logic                    arvalid_q, arvalid_d;
    logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
    logic [3:0]              arlen_q, arlen_d;
    logic [2:0]              arsize_q, arsize_d;
    logic [1:0]              arburst_q, arburst_d;
    logic [CNT_WIDTH-1:0]    hit_cnt_q, hit_cnt_d;
    logic [CNT_WIDTH-1:0]    miss_cnt_q, miss_cnt_d;
    logic                    accept;

    // One registered write may still land after afull rises; the FIFOs
    // assert afull with one entry of slack to absorb it.
    assign tc_ready_o = (state_q == IDLE)
                      & ~hit_flag_fifo_afull_i
                      & ~hit_data_fifo_afull_i;
    assign accept = tc_valid_i & tc_ready_o;

    always_comb begin
        state_d      = state_q;
        flag_wren_d  = 1'b0;
        flag_wdata_d = flag_wdata_q;
        data_wren_d  = 1'b0;
        data_wdata_d = data_wdata_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arsize_d     = arsize_q;
        arburst_d    = arburst_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    flag_wren_d  = 1'b1;
                    flag_wdata_d = tc_hit_i;
                    if (tc_hit_i) begin
                        data_wren_d  = 1'b1;
                        data_wdata_d = {tc_addr_i[5:0], tc_line_i};
                        if (~&hit_cnt_q) begin
                            hit_cnt_d = hit_cnt_q + CNT_WIDTH'(1);
                        end
                    end else begin
                        // Critical word first: 8-byte aligned start, wrap burst
                        arvalid_d = 1'b1;
                        araddr_d  = {tc_addr_i[ADDR_WIDTH-1:3], 3'b000};
                        arlen_d   = 4'd7;
                        arsize_d  = 3'b011;
                        arburst_d = 2'b10;
                        state_d   = AR_WAIT;
                        if (~&miss_cnt_q) begin
                            miss_cnt_d = miss_cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end
            end
            AR_WAIT: begin
                if (mem_arready_i) begin
                    arvalid_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                arvalid_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            flag_wren_q  <= 1'b0;
            flag_wdata_q <= 1'b0;
            data_wren_q  <= 1'b0;
            data_wdata_q <= '0;
            arvalid_q    <= 1'b0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arsize_q     <= '0;
            arburst_q    <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            flag_wren_q  <= flag_wren_d;
            flag_wdata_q <= flag_wdata_d;
            data_wren_q  <= data_wren_d;
            data_wdata_q <= data_wdata_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arsize_q     <= arsize_d;
            arburst_q    <= arburst_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign hit_flag_fifo_wren_o  = flag_wren_q;
    assign hit_flag_fifo_wdata_o = flag_wdata_q;
    assign hit_data_fifo_wren_o  = data_wren_q;
    assign hit_data_fifo_wdata_o = data_wdata_q;
    assign mem_arvalid_o         = arvalid_q;
    assign mem_araddr_o          = araddr_q;
    assign mem_arlen_o           = arlen_q;
    assign mem_arsize_o          = arsize_q;
    assign mem_arburst_o         = arburst_q;
    assign hit_cnt_o             = hit_cnt_q;
    assign miss_cnt_o            = miss_cnt_q;

endmodule

// File: tb/tb_cc_hit_miss_dispatch.sv
// Directed bench for cc_hit_miss_dispatch with 4-bit statistics counters.
module tb_cc_hit_miss_dispatch;

    localparam int AW = 32;
    localparam int LW = 512;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          tc_valid_i;
    logic          tc_ready_o;
    logic          tc_hit_i;
    logic [AW-1:0] tc_addr_i;
    logic [LW-1:0] tc_line_i;
    logic          flag_afull;
    logic          flag_wren;
    logic          flag_wdata;
    logic          data_afull;
    logic          data_wren;
    logic [LW+5:0] data_wdata;
    logic [AW-1:0] araddr;
    logic [3:0]    arlen;
    logic [2:0]    arsize;
    logic [1:0]    arburst;
    logic          arvalid;
    logic          arready;
    logic [CW-1:0] hit_cnt;
    logic [CW-1:0] miss_cnt;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cc_hit_miss_dispatch #(
        .ADDR_WIDTH(AW),
        .LINE_WIDTH(LW),
        .CNT_WIDTH (CW)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .tc_valid_i            (tc_valid_i),
        .tc_ready_o            (tc_ready_o),
        .tc_hit_i              (tc_hit_i),
        .tc_addr_i             (tc_addr_i),
        .tc_line_i             (tc_line_i),
        .hit_flag_fifo_afull_i (flag_afull),
        .hit_flag_fifo_wren_o  (flag_wren),
        .hit_flag_fifo_wdata_o (flag_wdata),
        .hit_data_fifo_afull_i (data_afull),
        .hit_data_fifo_wren_o  (data_wren),
        .hit_data_fifo_wdata_o (data_wdata),
        .mem_araddr_o          (araddr),
        .mem_arlen_o           (arlen),
        .mem_arsize_o          (arsize),
        .mem_arburst_o         (arburst),
        .mem_arvalid_o         (arvalid),
        .mem_arready_i         (arready),
        .hit_cnt_o             (hit_cnt),
        .miss_cnt_o            (miss_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst        = 1'b1;
        tc_valid_i = 1'b0;
        tc_hit_i   = 1'b0;
        tc_addr_i  = '0;
        tc_line_i  = '0;
        flag_afull = 1'b0;
        data_afull = 1'b0;
        arready    = 1'b0;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset_dut();
        checks++;
        if (flag_wren !== 1'b0 || data_wren !== 1'b0 || arvalid !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobes got fw=%b dw=%b arv=%b want 0 0 0",
                     flag_wren, data_wren, arvalid);
        end
        checks++;
        if (araddr !== '0 || data_wdata !== '0) begin
            failures++;
            $display("FAIL reset_regs got araddr=%h wdata_nz=%b want 0",
                     araddr, |data_wdata);
        end
        checks++;
        if (hit_cnt !== 4'd0 || miss_cnt !== 4'd0) begin
            failures++;
            $display("FAIL reset_cnt got %0d/%0d want 0/0", hit_cnt, miss_cnt);
        end
        checks++;
        if (tc_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready got %b want 1", tc_ready_o);
        end
    endtask

    task automatic test_hit();
        logic [LW-1:0]  line;
        logic [LW+5:0]  exp_d;
        reset_dut();
        line = {64{8'hA5}};
        exp_d = {6'h38, line};
        tc_valid_i = 1'b1;
        tc_hit_i   = 1'b1;
        tc_addr_i  = 32'h0000_1238;
        tc_line_i  = line;
        tick();
        tc_valid_i = 1'b0;
        checks++;
        if (flag_wren !== 1'b1 || flag_wdata !== 1'b1) begin
            failures++;
            $display("FAIL hit_flag got wren=%b wdata=%b want 1 1",
                     flag_wren, flag_wdata);
        end
        checks++;
        if (data_wren !== 1'b1 || data_wdata !== exp_d) begin
            failures++;
            $display("FAIL hit_data got wren=%b off=%h want 1 off=38 line_ok=%b",
                     data_wren, data_wdata[LW+5:LW], data_wdata[LW-1:0] == line);
        end
        checks++;
        if (arvalid !== 1'b0 || hit_cnt !== 4'd1 || miss_cnt !== 4'd0) begin
            failures++;
            $display("FAIL hit_side got arv=%b hc=%0d mc=%0d want 0 1 0",
                     arvalid, hit_cnt, miss_cnt);
        end
        tick();
        checks++;
        if (flag_wren !== 1'b0 || data_wren !== 1'b0) begin
            failures++;
            $display("FAIL hit_pulse got fw=%b dw=%b want 0 0", flag_wren, data_wren);
        end
    endtask

    task automatic test_miss();
        logic stable_ok;
        reset_dut();
        tc_valid_i = 1'b1;
        tc_hit_i   = 1'b0;
        tc_addr_i  = 32'h8000_0044;
        tick();
        tc_valid_i = 1'b0;
        checks++;
        if (flag_wren !== 1'b1 || flag_wdata !== 1'b0 || data_wren !== 1'b0) begin
            failures++;
            $display("FAIL miss_flag got fw=%b fd=%b dw=%b want 1 0 0",
                     flag_wren, flag_wdata, data_wren);
        end
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h8000_0040 || arlen !== 4'd7 ||
            arsize !== 3'd3 || arburst !== 2'd2) begin
            failures++;
            $display("FAIL miss_ar got v=%b a=%h l=%0d s=%0d b=%0d want 1 80000040 7 3 2",
                     arvalid, araddr, arlen, arsize, arburst);
        end
        checks++;
        if (miss_cnt !== 4'd1 || tc_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL miss_cnt got mc=%0d rdy=%b want 1 0", miss_cnt, tc_ready_o);
        end
        // A hit offered while waiting must be ignored
        tc_valid_i = 1'b1;
        tc_hit_i   = 1'b1;
        tc_addr_i  = 32'h0000_0100;
        stable_ok  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (arvalid !== 1'b1 || araddr !== 32'h8000_0040 || arlen !== 4'd7 ||
                arsize !== 3'd3 || arburst !== 2'd2 || tc_ready_o !== 1'b0 ||
                flag_wren !== 1'b0 || data_wren !== 1'b0)
                stable_ok = 1'b0;
        end
        checks++;
        if (stable_ok !== 1'b1) begin
            failures++;
            $display("FAIL miss_hold got stable=%b want 1", stable_ok);
        end
        tc_valid_i = 1'b0;
        arready    = 1'b1;
        tick();
        arready = 1'b0;
        checks++;
        if (arvalid !== 1'b0 || tc_ready_o !== 1'b1 || hit_cnt !== 4'd0) begin
            failures++;
            $display("FAIL miss_done got arv=%b rdy=%b hc=%0d want 0 1 0",
                     arvalid, tc_ready_o, hit_cnt);
        end
    endtask

    task automatic test_sequence();
        logic       items [3];
        logic       flags [$];
        int         k;
        int         ndata;
        int         nar;
        int         arv_cyc;
        logic       acc;
        logic       hs;
        logic       order_ok;
        reset_dut();
        items = '{1'b1, 1'b0, 1'b1};
        k = 0;
        ndata = 0;
        nar = 0;
        arv_cyc = 0;
        order_ok = 1'b1;
        tc_valid_i = 1'b1;
        tc_hit_i   = items[0];
        tc_addr_i  = 32'h0000_2000;
        for (int c = 0; c < 14; c++) begin
            acc = tc_ready_o & tc_valid_i;
            if (acc && k == 2 && arvalid !== 1'b0)
                order_ok = 1'b0;
            hs = arvalid & arready;
            tick();
            if (flag_wren === 1'b1) flags.push_back(flag_wdata);
            if (data_wren === 1'b1) ndata++;
            if (hs) nar++;
            if (acc) begin
                k++;
                if (k < 3) begin
                    tc_hit_i  = items[k];
                    tc_addr_i = tc_addr_i + 32'h40;
                end else begin
                    tc_valid_i = 1'b0;
                end
            end
            if (arvalid === 1'b1) begin
                arv_cyc++;
                arready = (arv_cyc >= 2);
            end else begin
                arv_cyc = 0;
                arready = 1'b0;
            end
        end
        tc_valid_i = 1'b0;
        arready    = 1'b0;
        checks++;
        if (k != 3) begin
            failures++;
            $display("FAIL seq_timeout got accepts=%0d want 3", k);
        end
        checks++;
        if (flags.size() != 3 || flags[0] !== 1'b1 || flags[1] !== 1'b0 ||
            flags[2] !== 1'b1) begin
            failures++;
            $display("FAIL seq_flags got n=%0d want 3 flags 1,0,1", flags.size());
        end
        checks++;
        if (ndata != 2 || nar != 1 || order_ok !== 1'b1) begin
            failures++;
            $display("FAIL seq_counts got data=%0d ar=%0d order=%b want 2 1 1",
                     ndata, nar, order_ok);
        end
    endtask

    task automatic test_back_to_back();
        int   occ;
        int   docc;
        int   maxocc;
        int   nacc;
        logic acc;
        reset_dut();
        occ = 0;
        docc = 0;
        maxocc = 0;
        nacc = 0;
        tc_valid_i = 1'b1;
        tc_hit_i   = 1'b1;
        tc_addr_i  = 32'h0000_3008;
        tc_line_i  = {16{32'hDEAD_BEEF}};
        for (int c = 0; c < 30; c++) begin
            acc = tc_ready_o & tc_valid_i;
            tick();
            if (flag_wren === 1'b1) occ++;
            if (data_wren === 1'b1) docc++;
            if (occ > maxocc) maxocc = occ;
            if (acc) nacc++;
            if (nacc >= 20) tc_valid_i = 1'b0;
            flag_afull = (occ >= 15);
            data_afull = (docc >= 15);
            #1;
        end
        checks++;
        if (occ != 15 || docc != 15 || maxocc > 16) begin
            failures++;
            $display("FAIL b2b_fill got flag=%0d data=%0d max=%0d want 15 15 <=16",
                     occ, docc, maxocc);
        end
        checks++;
        if (tc_ready_o !== 1'b0 || hit_cnt !== 4'd15) begin
            failures++;
            $display("FAIL b2b_stall got rdy=%b hc=%0d want 0 15", tc_ready_o, hit_cnt);
        end
        occ--;
        docc--;
        flag_afull = (occ >= 15);
        data_afull = (docc >= 15);
        #1;
        checks++;
        if (tc_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL b2b_resume_ready got %b want 1", tc_ready_o);
        end
        tick();
        // afull rises with this write in flight; the write must stand
        flag_afull = 1'b1;
        data_afull = 1'b1;
        #1;
        checks++;
        if (flag_wren !== 1'b1 || data_wren !== 1'b1 || tc_ready_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_resume_write got fw=%b dw=%b rdy=%b want 1 1 0",
                     flag_wren, data_wren, tc_ready_o);
        end
        tick();
        checks++;
        if (flag_wren !== 1'b0 || data_wren !== 1'b0 || hit_cnt !== 4'd15) begin
            failures++;
            $display("FAIL b2b_after got fw=%b dw=%b hc=%0d want 0 0 15",
                     flag_wren, data_wren, hit_cnt);
        end
        tc_valid_i = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        reset_dut();
        tc_valid_i = 1'b1;
        tc_hit_i   = 1'b0;
        tc_addr_i  = 32'h8000_0044;
        tick();
        tc_valid_i = 1'b0;
        tick();
        checks++;
        if (arvalid !== 1'b1 || miss_cnt !== 4'd1) begin
            failures++;
            $display("FAIL rstmid_pre got arv=%b mc=%0d want 1 1", arvalid, miss_cnt);
        end
        rst        = 1'b1;
        tc_valid_i = 1'b1;
        tc_hit_i   = 1'b1;
        tick();
        rst        = 1'b0;
        tc_valid_i = 1'b0;
        #1;
        checks++;
        if (arvalid !== 1'b0 || araddr !== '0 || tc_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_ar got arv=%b a=%h rdy=%b want 0 0 1",
                     arvalid, araddr, tc_ready_o);
        end
        checks++;
        if (hit_cnt !== 4'd0 || miss_cnt !== 4'd0 || flag_wren !== 1'b0 ||
            data_wren !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_cnt got hc=%0d mc=%0d fw=%b dw=%b want 0 0 0 0",
                     hit_cnt, miss_cnt, flag_wren, data_wren);
        end
        tick();
        checks++;
        if (flag_wren !== 1'b0 || data_wren !== 1'b0 || arvalid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_quiet got fw=%b dw=%b arv=%b want 0 0 0",
                     flag_wren, data_wren, arvalid);
        end
    endtask

    task automatic test_saturate();
        reset_dut();
        tc_valid_i = 1'b1;
        tc_hit_i   = 1'b1;
        tc_addr_i  = 32'h0000_0010;
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (hit_cnt !== 4'd14) begin
            failures++;
            $display("FAIL sat_pre got %0d want 14", hit_cnt);
        end
        tick();
        tick();
        checks++;
        if (hit_cnt !== 4'hF) begin
            failures++;
            $display("FAIL sat_16 got %0d want 15", hit_cnt);
        end
        tick();
        tc_valid_i = 1'b0;
        checks++;
        if (hit_cnt !== 4'hF || miss_cnt !== 4'd0 || flag_wren !== 1'b1) begin
            failures++;
            $display("FAIL sat_17 got hc=%0d mc=%0d fw=%b want 15 0 1",
                     hit_cnt, miss_cnt, flag_wren);
        end
    endtask

    initial begin
        test_reset();
        test_hit();
        test_miss();
        test_sequence();
        test_back_to_back();
        test_reset_mid_burst();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
